// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RV32 subset datapath (lw/sw/R/I/beq/jal),
// with a memory-wait watchdog and a sticky error state.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALUOp_out,
  output logic [1:0] result_src,
  output logic [3:0] state_out,
  output logic       err
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ERROR    = 4'd15
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] wait_cnt_r;
  logic          err_r;
  logic          wait_state_s;
  logic          timeout_s;
  logic          pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;

  // Next-state logic; a memory handshake arriving on the timeout cycle still wins.
  always_comb begin
    wait_state_s = (state_r == FETCH) || (state_r == MEMREAD) || (state_r == MEMWRITE);
    timeout_s    = wait_state_s && !mem_ready && (wait_cnt_r == CW'(MEM_TIMEOUT));
    state_next_s = state_r;
    case (state_r)
      FETCH: begin
        if (timeout_s)      state_next_s = ERROR;
        else if (mem_ready) state_next_s = DECODE;
        else                state_next_s = FETCH;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next_s = MEMADR;
          OP_R:         state_next_s = EXECR;
          OP_I:         state_next_s = EXECI;
          OP_BEQ:       state_next_s = BEQ;
          OP_JAL:       state_next_s = JAL;
          default:      state_next_s = ERROR;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW) state_next_s = MEMREAD;
        else                 state_next_s = MEMWRITE;
      end
      MEMREAD: begin
        if (timeout_s)      state_next_s = ERROR;
        else if (mem_ready) state_next_s = MEMWB;
        else                state_next_s = MEMREAD;
      end
      MEMWRITE: begin
        if (timeout_s)      state_next_s = ERROR;
        else if (mem_ready) state_next_s = FETCH;
        else                state_next_s = MEMWRITE;
      end
      MEMWB, ALUWB, BEQ: state_next_s = FETCH;
      EXECR, EXECI, JAL: state_next_s = ALUWB;
      ERROR:             state_next_s = ERROR;
      default:           state_next_s = ERROR;
    endcase
  end

  // State, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FETCH;
      wait_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      err_r   <= err_r || (state_next_s == ERROR);
      if (state_next_s != state_r)       wait_cnt_r <= '0;
      else if (wait_state_s && !mem_ready) wait_cnt_r <= wait_cnt_r + 1'b1;
      else                               wait_cnt_r <= '0;
    end
  end

  // Moore output decode from the state register; unlisted outputs stay 0.
  always_comb begin
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    ALUOp_out   = 2'b00;
    result_src  = 2'b00;
    case (state_r)
      FETCH: begin
        mem_read_s = 1'b1;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        mem_read_s = 1'b1;
        adr_src    = 1'b1;
      end
      MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      MEMWRITE: begin
        mem_write_s = 1'b1;
        adr_src     = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        ALUOp_out = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        ALUOp_out = 2'b10;
      end
      ALUWB: reg_write_s = 1'b1;
      BEQ: begin
        alu_src_a  = 2'b10;
        ALUOp_out  = 2'b01;
        pc_write_s = 1'b1;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_s = 1'b1;
      end
      ERROR:   pc_write_s = 1'b0;
      default: pc_write_s = 1'b0;
    endcase
  end

  // FETCH enables follow live mem_ready, so they are held off while reset is asserted.
  assign pc_write  = pc_write_s  & rst_n;
  assign ir_write  = ir_write_s  & rst_n;
  assign mem_read  = mem_read_s  & rst_n;
  assign mem_write = mem_write_s & rst_n;
  assign reg_write = reg_write_s & rst_n;
  assign state_out = state_r;
  assign err       = err_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state/output tables per instruction class.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, ALUOp_out, result_src;
  logic [3:0] state_out;
  logic       err;

  int tests_run = 0;
  int fails = 0;

  // {pc_write, ir_write, mem_read, mem_write, reg_write, adr_src, a, b, aluop, result_src}
  wire [13:0] outs = {pc_write, ir_write, mem_read, mem_write, reg_write, adr_src,
                      alu_src_a, alu_src_b, ALUOp_out, result_src};

  localparam logic [13:0] O_FETCH1 = 14'b111000_00100010;
  localparam logic [13:0] O_FETCH0 = 14'b001000_00100010;
  localparam logic [13:0] O_DECODE = 14'b000000_01010000;
  localparam logic [13:0] O_MEMADR = 14'b000000_10010000;
  localparam logic [13:0] O_MEMRD  = 14'b001001_00000000;
  localparam logic [13:0] O_MEMWB  = 14'b000010_00000001;
  localparam logic [13:0] O_MEMWR  = 14'b000101_00000000;
  localparam logic [13:0] O_EXECR  = 14'b000000_10001000;
  localparam logic [13:0] O_EXECI  = 14'b000000_10011000;
  localparam logic [13:0] O_ALUWB  = 14'b000010_00000000;
  localparam logic [13:0] O_BEQ    = 14'b100000_10000100;
  localparam logic [13:0] O_JAL    = 14'b100000_01100000;
  localparam logic [13:0] O_NONE   = 14'b000000_00000000;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp_out(ALUOp_out),
    .result_src(result_src), .state_out(state_out), .err(err)
  );

  always #5 clk = ~clk;

  // Leaves the bench 1 time unit after a rising edge, in FETCH with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    opcode = OP_R;
    mem_ready = 1'b1;
    #2;
    tests_run++;
    if (state_out !== 4'd0) begin
      fails++; $display("FAIL reset_state: got %0d want 0", state_out);
    end
    tests_run++;
    if ({pc_write, ir_write, mem_read, mem_write, reg_write} !== 5'b00000) begin
      fails++; $display("FAIL reset_enables: got %b want 00000",
                        {pc_write, ir_write, mem_read, mem_write, reg_write});
    end
    tests_run++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL reset_err: got %b want 0", err);
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (state_out !== 4'd0 || outs !== O_FETCH0) begin
      fails++; $display("FAIL reset_release_fetch: got state %0d outs %b want 0 %b",
                        state_out, outs, O_FETCH0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rtype();
    logic [3:0]  st [5];
    logic [13:0] ou [5];
    st = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    ou = '{O_FETCH1, O_DECODE, O_EXECR, O_ALUWB, O_FETCH1};
    do_reset();
    opcode = OP_R;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (state_out !== st[i] || outs !== ou[i]) begin
        fails++; $display("FAIL rtype cyc %0d: got state %0d outs %b want %0d %b",
                          i, state_out, outs, st[i], ou[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  st [9];
    logic [13:0] ou [9];
    logic        mr [9];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    ou = '{O_FETCH1, O_DECODE, O_MEMADR, O_MEMRD, O_MEMRD, O_MEMRD, O_MEMRD, O_MEMWB, O_FETCH0};
    mr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    opcode = OP_LW;
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr[i];
      @(negedge clk);
      tests_run++;
      if (state_out !== st[i] || outs !== ou[i]) begin
        fails++; $display("FAIL lw_wait cyc %0d: got state %0d outs %b want %0d %b",
                          i, state_out, outs, st[i], ou[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_beq();
    logic [3:0]  st [4];
    logic [13:0] ou [4];
    st = '{4'd0, 4'd1, 4'd9, 4'd0};
    ou = '{O_FETCH1, O_DECODE, O_BEQ, O_FETCH1};
    do_reset();
    opcode = OP_BEQ;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (state_out !== st[i] || outs !== ou[i]) begin
        fails++; $display("FAIL beq cyc %0d: got state %0d outs %b want %0d %b",
                          i, state_out, outs, st[i], ou[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_jal();
    logic [3:0]  st [5];
    logic [13:0] ou [5];
    st = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
    ou = '{O_FETCH1, O_DECODE, O_JAL, O_ALUWB, O_FETCH1};
    do_reset();
    opcode = OP_JAL;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (state_out !== st[i] || outs !== ou[i]) begin
        fails++; $display("FAIL jal cyc %0d: got state %0d outs %b want %0d %b",
                          i, state_out, outs, st[i], ou[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // I-type followed directly by a sw without an intervening reset.
  task automatic test_back_to_back();
    logic [3:0]  st [9];
    logic [13:0] ou [9];
    logic [6:0]  op [9];
    st = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    ou = '{O_FETCH1, O_DECODE, O_EXECI, O_ALUWB, O_FETCH1, O_DECODE, O_MEMADR, O_MEMWR, O_FETCH1};
    op = '{OP_I, OP_I, OP_I, OP_I, OP_I, OP_SW, OP_SW, OP_SW, OP_SW};
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      opcode = op[i];
      @(negedge clk);
      tests_run++;
      if (state_out !== st[i] || outs !== ou[i]) begin
        fails++; $display("FAIL back_to_back cyc %0d: got state %0d outs %b want %0d %b",
                          i, state_out, outs, st[i], ou[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = OP_BAD;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      mem_ready = i[0];
      @(negedge clk);
      tests_run++;
      if (state_out !== 4'd15 || err !== 1'b1 || outs !== O_NONE) begin
        fails++; $display("FAIL illegal_error cyc %0d: got state %0d err %b outs %b want 15 1 %b",
                          i, state_out, err, outs, O_NONE);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (state_out !== 4'd0 || err !== 1'b0) begin
      fails++; $display("FAIL illegal_reset_clear: got state %0d err %b want 0 0", state_out, err);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = OP_R;
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tests_run++;
      if (state_out !== 4'd0 || err !== 1'b0) begin
        fails++; $display("FAIL timeout_wait cyc %0d: got state %0d err %b want 0 0",
                          i, state_out, err);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    tests_run++;
    if (state_out !== 4'd15 || err !== 1'b1 || outs !== O_NONE) begin
      fails++; $display("FAIL timeout_error: got state %0d err %b outs %b want 15 1 %b",
                        state_out, err, outs, O_NONE);
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mem_ready = (i == 15);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    tests_run++;
    if (state_out !== 4'd1 || err !== 1'b0) begin
      fails++; $display("FAIL timeout_ready_wins: got state %0d err %b want 1 0", state_out, err);
    end
    // A shorter stall in MEMWRITE must not trip the watchdog.
    do_reset();
    opcode = OP_SW;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests_run++;
    if (state_out !== 4'd5 || err !== 1'b0) begin
      fails++; $display("FAIL memwrite_stall: got state %0d err %b want 5 0", state_out, err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = OP_SW;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (state_out !== 4'd5 || mem_write !== 1'b1) begin
      fails++; $display("FAIL mid_memwrite: got state %0d mem_write %b want 5 1", state_out, mem_write);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (state_out !== 4'd0 || mem_write !== 1'b0) begin
      fails++; $display("FAIL mid_reset_async: got state %0d mem_write %b want 0 0",
                        state_out, mem_write);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (state_out !== 4'd0 || mem_read !== 1'b1) begin
      fails++; $display("FAIL mid_reset_refetch: got state %0d mem_read %b want 0 1",
                        state_out, mem_read);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_jal();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
